// File: rtl/rob_commit_if.sv
// Issue / CDB / regfile / forwarding bundle between the pipeline and the
// reorder-buffer controller. The ROB takes the slave view; the pipeline side
// (issue stage, CDB, regfile) takes the master view.
interface rob_commit_if #(
    parameter int Q_WIDTH        = 4,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      issue_valid;
    logic                      issue_has_rd;
    logic [REG_ADDR_WIDTH-1:0] issue_rd;
    logic                      issue_ready;
    logic [Q_WIDTH-1:0]        issue_tag;
    logic                      rd_control;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [Q_WIDTH-1:0]        Q_value;
    logic                      wb_valid;
    logic [Q_WIDTH-1:0]        wb_tag;
    logic [31:0]               wb_value;
    logic                      has_commit;
    logic [REG_ADDR_WIDTH-1:0] commit_target;
    logic [Q_WIDTH-1:0]        Commit_Q;
    logic [31:0]               Commit_V;
    logic [Q_WIDTH-1:0]        fwd_q1;
    logic [Q_WIDTH-1:0]        fwd_q2;
    logic                      fwd_rdy1;
    logic                      fwd_rdy2;
    logic [31:0]               fwd_v1;
    logic [31:0]               fwd_v2;

    modport master (
        output issue_valid, issue_has_rd, issue_rd,
        output wb_valid, wb_tag, wb_value,
        output fwd_q1, fwd_q2,
        input  issue_ready, issue_tag, rd_control, rd, Q_value,
        input  has_commit, commit_target, Commit_Q, Commit_V,
        input  fwd_rdy1, fwd_rdy2, fwd_v1, fwd_v2
    );

    modport slave (
        input  issue_valid, issue_has_rd, issue_rd,
        input  wb_valid, wb_tag, wb_value,
        input  fwd_q1, fwd_q2,
        output issue_ready, issue_tag, rd_control, rd, Q_value,
        output has_commit, commit_target, Commit_Q, Commit_V,
        output fwd_rdy1, fwd_rdy2, fwd_v1, fwd_v2
    );
endinterface

// File: rtl/rob_commit_ctrl.sv
// In-order reorder-buffer controller: allocates rename tags at issue, collects
// CDB results, and retires one entry per cycle in program order to the regfile.
// Tag 0 means "no dependency", so entries live in slots 1..2**Q_WIDTH-1 and the
// head/tail pointers wrap from the all-ones tag back to 1.
// Optional feature: define ROB_FWD_EN to enable the combinational operand
// forwarding lookup; without it the fwd_* outputs are tied to zero.
module rob_commit_ctrl #(
    parameter int Q_WIDTH        = 4,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic         clk_in,
    input  logic         rst_n_in,
    input  logic         rdy_in,
    input  logic         flush_in,
    rob_commit_if.slave  bus
);
    localparam int                 NUM_SLOTS = 2 ** Q_WIDTH;
    localparam logic [Q_WIDTH-1:0] DEPTH     = '1;
    localparam logic [Q_WIDTH-1:0] ONE       = Q_WIDTH'(1);

    // Slot 0 is never allocated; it stays zero so a zero lookup reads zero.
    logic [NUM_SLOTS-1:0]      busy_q;
    logic [NUM_SLOTS-1:0]      ready_q;
    logic [REG_ADDR_WIDTH-1:0] dest_q  [NUM_SLOTS];
    logic [31:0]               value_q [NUM_SLOTS];

    logic [Q_WIDTH-1:0]        head_q, head_d;
    logic [Q_WIDTH-1:0]        tail_q, tail_d;
    logic [Q_WIDTH-1:0]        count_q, count_d;

    logic                      has_commit_q;
    logic [REG_ADDR_WIDTH-1:0] commit_target_q;
    logic [Q_WIDTH-1:0]        commit_tag_q;
    logic [31:0]               commit_value_q;

    logic issue_ready;
    logic accept;
    logic commit_fire;
    logic flush_eff;
    logic wb_hit;

    function automatic logic [Q_WIDTH-1:0] ptr_inc(input logic [Q_WIDTH-1:0] p);
        return (p == DEPTH) ? ONE : p + ONE;
    endfunction

    assign flush_eff   = flush_in && rdy_in;
    assign issue_ready = (count_q != DEPTH) && !flush_in;
    assign accept      = bus.issue_valid && issue_ready && rdy_in;
    // Flush squashes a commit that would otherwise fire on the same edge.
    assign commit_fire = (count_q != '0) && busy_q[head_q] && ready_q[head_q]
                         && rdy_in && !flush_in;
    assign wb_hit      = bus.wb_valid && (bus.wb_tag != '0) && busy_q[bus.wb_tag];

    // Pointer and occupancy next-state.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_eff) begin
            head_d  = ONE;
            tail_d  = ONE;
            count_d = '0;
        end else begin
            if (accept)      tail_d = ptr_inc(tail_q);
            if (commit_fire) head_d = ptr_inc(head_q);
            if (accept && !commit_fire)      count_d = count_q + ONE;
            else if (!accept && commit_fire) count_d = count_q - ONE;
        end
    end

    // Entry storage, pointers and the registered commit port.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            busy_q          <= '0;
            ready_q         <= '0;
            head_q          <= ONE;
            tail_q          <= ONE;
            count_q         <= '0;
            has_commit_q    <= 1'b0;
            commit_target_q <= '0;
            commit_tag_q    <= '0;
            commit_value_q  <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                dest_q[i]  <= '0;
                value_q[i] <= '0;
            end
        end else if (!rdy_in) begin
            has_commit_q <= 1'b0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            has_commit_q <= commit_fire;
            if (flush_eff) begin
                busy_q  <= '0;
                ready_q <= '0;
            end else begin
                if (wb_hit) begin
                    value_q[bus.wb_tag] <= bus.wb_value;
                    ready_q[bus.wb_tag] <= 1'b1;
                end
                // Placed after writeback so retiring an entry always frees it.
                if (commit_fire) begin
                    commit_target_q <= dest_q[head_q];
                    commit_tag_q    <= head_q;
                    commit_value_q  <= value_q[head_q];
                    busy_q[head_q]  <= 1'b0;
                    ready_q[head_q] <= 1'b0;
                end
                // Tail is never busy when accepting, so this cannot collide
                // with the commit or writeback updates above.
                if (accept) begin
                    busy_q[tail_q]  <= 1'b1;
                    ready_q[tail_q] <= 1'b0;
                    dest_q[tail_q]  <= bus.issue_has_rd ? bus.issue_rd : '0;
                end
            end
        end
    end

    assign bus.issue_ready   = issue_ready;
    assign bus.issue_tag     = tail_q;
    assign bus.rd_control    = accept && bus.issue_has_rd && (bus.issue_rd != '0);
    assign bus.rd            = bus.issue_rd;
    assign bus.Q_value       = tail_q;
    assign bus.has_commit    = has_commit_q;
    assign bus.commit_target = commit_target_q;
    assign bus.Commit_Q      = commit_tag_q;
    assign bus.Commit_V      = commit_value_q;

`ifdef ROB_FWD_EN
    logic cdb_hit1;
    logic cdb_hit2;

    // A result on the CDB this cycle is forwarded ahead of the stored copy.
    assign cdb_hit1 = bus.wb_valid && (bus.wb_tag == bus.fwd_q1)
                      && (bus.fwd_q1 != '0) && busy_q[bus.fwd_q1];
    assign cdb_hit2 = bus.wb_valid && (bus.wb_tag == bus.fwd_q2)
                      && (bus.fwd_q2 != '0) && busy_q[bus.fwd_q2];

    assign bus.fwd_rdy1 = cdb_hit1 || ((bus.fwd_q1 != '0) && busy_q[bus.fwd_q1]
                                       && ready_q[bus.fwd_q1]);
    assign bus.fwd_rdy2 = cdb_hit2 || ((bus.fwd_q2 != '0) && busy_q[bus.fwd_q2]
                                       && ready_q[bus.fwd_q2]);
    assign bus.fwd_v1   = cdb_hit1 ? bus.wb_value : value_q[bus.fwd_q1];
    assign bus.fwd_v2   = cdb_hit2 ? bus.wb_value : value_q[bus.fwd_q2];
`else
    logic unused_fwd;

    assign unused_fwd   = ^{bus.fwd_q1, bus.fwd_q2};
    assign bus.fwd_rdy1 = 1'b0;
    assign bus.fwd_rdy2 = 1'b0;
    assign bus.fwd_v1   = '0;
    assign bus.fwd_v2   = '0;
`endif

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Bench for rob_commit_ctrl: a queue-based model of the in-flight instructions
// is checked against the DUT every cycle, plus literal expectations from the
// directed scenarios.
module tb_rob_commit_ctrl;
    localparam int QW    = 4;
    localparam int RW    = 5;
    localparam int DEPTH = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rdy   = 1'b1;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    rob_commit_if #(.Q_WIDTH(QW), .REG_ADDR_WIDTH(RW)) bus ();

    rob_commit_ctrl #(.Q_WIDTH(QW), .REG_ADDR_WIDTH(RW)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .rdy_in   (rdy),
        .flush_in (flush),
        .bus      (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: program-ordered list of in-flight instructions.
    typedef struct {
        int          tag;
        int          dest;
        bit          rdy;
        logic [31:0] val;
    } ent_t;

    ent_t        rob[$];
    int          m_tail = 1;
    bit          m_hc   = 0;
    int          m_ct   = 0;
    int          m_cq   = 0;
    logic [31:0] m_cv   = '0;

    task automatic model_edge();
        bit   acc;
        ent_t e;
        acc  = bus.issue_valid && (rob.size() < DEPTH);
        m_hc = 0;
        if (rob.size() > 0 && rob[0].rdy) begin
            m_hc = 1;
            m_ct = rob[0].dest;
            m_cq = rob[0].tag;
            m_cv = rob[0].val;
            rob.delete(0);
        end
        if (bus.wb_valid) begin
            foreach (rob[i]) begin
                if (rob[i].tag == int'(bus.wb_tag)) begin
                    rob[i].rdy = 1;
                    rob[i].val = bus.wb_value;
                end
            end
        end
        if (acc) begin
            e.tag  = m_tail;
            e.dest = bus.issue_has_rd ? int'(bus.issue_rd) : 0;
            e.rdy  = 0;
            e.val  = '0;
            rob.push_back(e);
            m_tail = (m_tail == DEPTH) ? 1 : m_tail + 1;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rob.delete();
            m_tail = 1;
            m_hc   = 0;
            m_ct   = 0;
            m_cq   = 0;
            m_cv   = '0;
        end else if (!rdy) begin
            m_hc = 0;
        end else if (flush) begin
            rob.delete();
            m_tail = 1;
            m_hc   = 0;
        end else begin
            model_edge();
        end
    end

    function automatic void fwd_model(input logic [3:0] q, output bit r, output logic [31:0] v);
        r = 0;
        v = '0;
        if (q != 0) begin
            foreach (rob[i]) begin
                if (rob[i].tag == int'(q)) begin
                    if (bus.wb_valid && bus.wb_tag == q) begin
                        r = 1;
                        v = bus.wb_value;
                    end else if (rob[i].rdy) begin
                        r = 1;
                        v = rob[i].val;
                    end
                end
            end
        end
    endfunction

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin : cmp
        bit          er;
        bit          r1, r2;
        logic [31:0] v1, v2;
        if (rst_n) begin
            er = (rob.size() != DEPTH) && !flush;
            chk("issue_ready", bus.issue_ready, er);
            chk("issue_tag", bus.issue_tag, m_tail);
            chk("rd_control", bus.rd_control,
                bus.issue_valid && er && rdy && bus.issue_has_rd && (bus.issue_rd != 0));
            chk("rd", bus.rd, bus.issue_rd);
            chk("Q_value", bus.Q_value, m_tail);
            chk("has_commit", bus.has_commit, m_hc);
            if (m_hc) begin
                chk("commit_target", bus.commit_target, m_ct);
                chk("Commit_Q", bus.Commit_Q, m_cq);
                chk("Commit_V", bus.Commit_V, m_cv);
            end
`ifdef ROB_FWD_EN
            fwd_model(bus.fwd_q1, r1, v1);
            fwd_model(bus.fwd_q2, r2, v2);
            chk("fwd_rdy1", bus.fwd_rdy1, r1);
            chk("fwd_rdy2", bus.fwd_rdy2, r2);
            if (r1) chk("fwd_v1", bus.fwd_v1, v1);
            if (r2) chk("fwd_v2", bus.fwd_v2, v2);
`else
            r1 = 0; r2 = 0; v1 = '0; v2 = '0;
            chk("fwd_rdy1_off", bus.fwd_rdy1, r1);
            chk("fwd_rdy2_off", bus.fwd_rdy2, r2);
            chk("fwd_v1_off", bus.fwd_v1, v1);
            chk("fwd_v2_off", bus.fwd_v2, v2);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.issue_valid  = 1'b0;
        bus.issue_has_rd = 1'b0;
        bus.issue_rd     = '0;
        bus.wb_valid     = 1'b0;
        bus.wb_tag       = '0;
        bus.wb_value     = '0;
        bus.fwd_q1       = '0;
        bus.fwd_q2       = '0;
        flush            = 1'b0;
    endtask

    task automatic do_issue(input int r);
        bus.issue_valid  = 1'b1;
        bus.issue_has_rd = (r != 0);
        bus.issue_rd     = RW'(r);
        tick();
        bus.issue_valid  = 1'b0;
    endtask

    task automatic do_wb(input int t, input logic [31:0] v);
        bus.wb_valid = 1'b1;
        bus.wb_tag   = QW'(t);
        bus.wb_value = v;
        tick();
        bus.wb_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        idle_in();
        rdy   = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset and empty
        repeat (5) tick();
        #1;
        chk("rst_has_commit", bus.has_commit, 0);
        chk("rst_issue_ready", bus.issue_ready, 1);
        chk("rst_issue_tag", bus.issue_tag, 1);
        chk("rst_Commit_V", bus.Commit_V, 0);
        chk("rst_fwd_rdy1", bus.fwd_rdy1, 0);

        // Single issue / commit
        bus.issue_valid  = 1'b1;
        bus.issue_has_rd = 1'b1;
        bus.issue_rd     = 5'd3;
        #1;
        chk("single_rd_control", bus.rd_control, 1);
        chk("single_Q_value", bus.Q_value, 1);
        tick();
        bus.issue_valid = 1'b0;
        do_wb(1, 32'hDEADBEEF);
        tick();
        chk("single_has_commit", bus.has_commit, 1);
        chk("single_target", bus.commit_target, 3);
        chk("single_Q", bus.Commit_Q, 1);
        chk("single_V", bus.Commit_V, 32'hDEADBEEF);
        tick();
        chk("single_one_cycle", bus.has_commit, 0);

        // In-order retire: results arrive 3,2,1
        do_flush();
        do_issue(5);
        do_issue(6);
        do_issue(0);
        do_wb(3, 32'h33);
        do_wb(2, 32'h22);
        do_wb(1, 32'h11);
        tick();
        chk("order1_Q", bus.Commit_Q, 1);
        chk("order1_target", bus.commit_target, 5);
        chk("order1_V", bus.Commit_V, 32'h11);
        tick();
        chk("order2_hc", bus.has_commit, 1);
        chk("order2_Q", bus.Commit_Q, 2);
        chk("order2_target", bus.commit_target, 6);
        tick();
        chk("order3_hc", bus.has_commit, 1);
        chk("order3_Q", bus.Commit_Q, 3);
        chk("order3_target", bus.commit_target, 0);
        chk("order3_V", bus.Commit_V, 32'h33);
        tick();
        chk("order_done", bus.has_commit, 0);

        // Full and wrap
        do_flush();
        for (int i = 1; i <= DEPTH; i++) do_issue(i);
        #1;
        chk("full_issue_ready", bus.issue_ready, 0);
        chk("full_issue_tag", bus.issue_tag, 1);
        bus.issue_valid  = 1'b1;
        bus.issue_has_rd = 1'b1;
        bus.issue_rd     = 5'd20;
        #1;
        chk("full_rd_control", bus.rd_control, 0);
        tick();
        bus.issue_valid = 1'b0;
        do_wb(1, 32'hA1);
        bus.issue_valid = 1'b1;
        #1;
        chk("full_no_reuse", bus.issue_ready, 0);
        tick();
        bus.issue_valid = 1'b0;
        #1;
        chk("wrap_has_commit", bus.has_commit, 1);
        chk("wrap_issue_ready", bus.issue_ready, 1);
        chk("wrap_issue_tag", bus.issue_tag, 1);

        // Flush priority
        do_flush();
        do_issue(7);
        do_issue(8);
        do_issue(9);
        do_issue(10);
        do_wb(1, 32'h77);
        flush            = 1'b1;
        bus.issue_valid  = 1'b1;
        bus.issue_has_rd = 1'b1;
        bus.issue_rd     = 5'd12;
        #1;
        chk("flush_rd_control", bus.rd_control, 0);
        chk("flush_issue_ready", bus.issue_ready, 0);
        tick();
        flush           = 1'b0;
        bus.issue_valid = 1'b0;
        #1;
        chk("flush_no_commit", bus.has_commit, 0);
        chk("flush_issue_tag", bus.issue_tag, 1);
        chk("flush_issue_ready_after", bus.issue_ready, 1);

        // Forwarding lookup
        do_issue(1);
        do_issue(2);
        do_issue(3);
        do_issue(4);
        do_wb(2, 32'h55);
        bus.fwd_q1 = 4'd2;
        bus.fwd_q2 = 4'd0;
        #1;
`ifdef ROB_FWD_EN
        chk("fwd_stored_rdy", bus.fwd_rdy1, 1);
        chk("fwd_stored_v", bus.fwd_v1, 32'h55);
`else
        chk("fwd_off_rdy", bus.fwd_rdy1, 0);
        chk("fwd_off_v", bus.fwd_v1, 0);
`endif
        chk("fwd_zero_tag", bus.fwd_rdy2, 0);
        bus.wb_valid = 1'b1;
        bus.wb_tag   = 4'd4;
        bus.wb_value = 32'd7;
        bus.fwd_q1   = 4'd4;
        #1;
`ifdef ROB_FWD_EN
        chk("fwd_cdb_rdy", bus.fwd_rdy1, 1);
        chk("fwd_cdb_v", bus.fwd_v1, 32'd7);
`else
        chk("fwd_cdb_off_rdy", bus.fwd_rdy1, 0);
        chk("fwd_cdb_off_v", bus.fwd_v1, 0);
`endif
        tick();
        bus.wb_valid = 1'b0;
        bus.fwd_q1   = '0;

        // rdy_in low holds everything
        do_wb(1, 32'h99);
        rdy              = 1'b0;
        bus.issue_valid  = 1'b1;
        bus.issue_has_rd = 1'b1;
        bus.issue_rd     = 5'd5;
        #1;
        chk("stall_rd_control", bus.rd_control, 0);
        repeat (2) tick();
        chk("stall_no_commit", bus.has_commit, 0);
        bus.issue_valid = 1'b0;
        rdy             = 1'b1;
        tick();
        chk("resume_Q1", bus.Commit_Q, 1);
        chk("resume_V1", bus.Commit_V, 32'h99);
        tick();
        chk("resume_Q2", bus.Commit_Q, 2);
        chk("resume_V2", bus.Commit_V, 32'h55);

        // Asynchronous reset mid-operation
        #2 rst_n = 1'b0;
        #1;
        chk("arst_has_commit", bus.has_commit, 0);
        chk("arst_Commit_Q", bus.Commit_Q, 0);
        chk("arst_Commit_V", bus.Commit_V, 0);
        chk("arst_issue_tag", bus.issue_tag, 1);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("post_arst_ready", bus.issue_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
